morse_seq_queue: RTL

- Parametrised successor to the combinational first/second sequence split stage. It sits between the key-entry encoder and the character decoder/display path.
- Accepts one encoded Morse sequence per handshake, tagged EndSeq or Space, and expands it into 0, 1 or 2 words (sequence and/or space marker).
- Buffers the words in a DEPTH-entry FIFO and presents them one per handshake to the downstream decoder, each carrying its sentence-end flag.

---
 rtl/morse_seq_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/morse_seq_queue.sv
// Morse sequence queue: expands each accepted sequence into 0-2 words (sequence and/or
// space marker) and buffers them in a DEPTH-entry FIFO for the character decoder.
module morse_seq_queue #(
    parameter int unsigned SYMS  = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Clear,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [2*SYMS-1:0]         EncSeq,
    input  logic                      Space_EndSeqbar,
    input  logic                      SentFlag,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [2*SYMS-1:0]         OutSeq,
    output logic                      OutSentFlag,
    output logic [$clog2(DEPTH):0]    Count
);

    localparam int unsigned W  = 2 * SYMS;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [W-1:0] EMPTY  = '1;
    localparam logic [W-1:0] SPACEW = {2'b10, {(W-2){1'b1}}};

    typedef struct packed {
        logic [W-1:0] seq;
        logic         sent;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        w0;
    entry_t        w1;
    entry_t        head;
    logic [1:0]    push_n;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          in_empty;
    logic          accept;
    logic          pop;

    // Credit is taken from the registered count only; a same-cycle pop gives none.
    assign InReady  = !reset && !Clear && ((CW'(DEPTH) - Count) >= CW'(2));
    assign OutValid = (Count != '0);
    assign accept   = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign in_empty = (EncSeq[W-1 -: 2] == 2'b11);

    // Push decode: the sentence flag rides only on the last word of an accept.
    always_comb begin
        push_n = 2'd0;
        w0     = '{seq: EMPTY, sent: 1'b0};
        w1     = '{seq: EMPTY, sent: 1'b0};
        if (accept) begin
            case ({Space_EndSeqbar, in_empty})
                2'b00: begin
                    push_n = 2'd1;
                    w0     = '{seq: EncSeq, sent: SentFlag};
                end
                2'b10: begin
                    push_n = 2'd2;
                    w0     = '{seq: EncSeq, sent: 1'b0};
                    w1     = '{seq: SPACEW, sent: SentFlag};
                end
                2'b11: begin
                    push_n = 2'd1;
                    w0     = '{seq: SPACEW, sent: SentFlag};
                end
                default: push_n = 2'd0;
            endcase
        end
    end

    // Pointer and occupancy datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else if (Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            Count  <= Count + CW'(push_n) - CW'(pop);
        end
    end

    // Storage is not reset; the outputs mask it with EMPTY whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (!Clear) begin
            if (push_n != 2'd0) mem[wr_ptr] <= w0;
            if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= w1;
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        OutSeq      = EMPTY;
        OutSentFlag = 1'b0;
        if (OutValid) begin
            OutSeq      = head.seq;
            OutSentFlag = head.sent;
        end
    end

endmodule
